// File: rtl/seq1101_tx_if.sv
// Parallel producer handshake for seq1101_tx: one payload word per valid/ready transfer.
interface seq1101_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    // Producer side drives the word and valid, watches ready.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    // Transmitter side consumes the word and valid, reports ready.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/seq1101_tx.sv
// seq1101_tx: framed serial transmitter. Sends sync word 1101, then the payload
// MSB first, inserting a stuffed 0 after every 110 in the frame body so that
// 1101 can only appear as the real sync word.
// Optional macro SEQ1101_TX_PARITY_EN appends an even-parity bit after the payload.
module seq1101_tx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    seq1101_tx_if.slave bus,
    output logic        tx_bit,
    output logic        tx_active,
    output logic        tx_sync,
    output logic        tx_stuff,
    output logic        frame_done
);

    // idx counts sync bits (0..3) and payload bits (0..DATA_W)
    localparam int unsigned IDX_W = ($clog2(DATA_W + 1) > 2) ? $clog2(DATA_W + 1) : 2;
    localparam int unsigned GAP_W = ($clog2(GAP_CYCLES) > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [3:0]  SYNC_WORD  = 4'b1101;
    localparam logic [2:0]  STUFF_TRIG = 3'b110;

    // State names the kind of bit currently on tx_bit.
    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        PAR,
        GAP
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        hist;
`ifdef SEQ1101_TX_PARITY_EN
    logic              par_q;
    logic              par_done;
`endif

    logic [2:0]        win;
    logic [IDX_W-1:0]  res_n;
    state_t            res_state;
    logic              res_bit;
    logic              res_active;
    logic              go_stuff;
    logic              go_resume;

    // Accept only in IDLE and never while reset is asserted.
    assign bus.in_ready = (state == IDLE) && !rst;

    // Last three frame bits, newest being the bit on the line right now.
    assign win = {hist[1:0], tx_bit};

    // Where the frame continues after the current bit (or after a stuff bit):
    // next payload bit, then parity if enabled, then the gap.
    always_comb begin
        if (state == DATA) begin
            res_n = idx + IDX_W'(1);
        end else if (state == SYNC) begin
            res_n = '0;
        end else begin
            res_n = idx;
        end
        res_state  = GAP;
        res_bit    = 1'b0;
        res_active = 1'b0;
        if (res_n < IDX_W'(DATA_W)) begin
            res_state  = DATA;
            res_bit    = data_q[DATA_W-1];
            res_active = 1'b1;
        end
`ifdef SEQ1101_TX_PARITY_EN
        else if (!par_done) begin
            res_state  = PAR;
            res_bit    = par_q;
            res_active = 1'b1;
        end
`endif
    end

    // Decide between inserting a stuff bit and moving on to the pending bit.
    always_comb begin
        go_stuff  = ((state == DATA) || (state == PAR)) && (win == STUFF_TRIG);
        go_resume = 1'b0;
        case (state)
            SYNC:      go_resume = (idx == IDX_W'(3));
            DATA, PAR: go_resume = (win != STUFF_TRIG);
            STUFF:     go_resume = 1'b1;
            default:   go_resume = 1'b0;
        endcase
    end

    // Frame sequencer with registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            gap_cnt    <= '0;
            data_q     <= '0;
            hist       <= '0;
            tx_bit     <= 1'b0;
            tx_active  <= 1'b0;
            tx_sync    <= 1'b0;
            tx_stuff   <= 1'b0;
            frame_done <= 1'b0;
`ifdef SEQ1101_TX_PARITY_EN
            par_q      <= 1'b0;
            par_done   <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (tx_active) begin
                hist <= win;
            end

            case (state)
                IDLE: begin
                    hist <= '0;
                    if (bus.in_valid && bus.in_ready) begin
                        data_q    <= bus.in_data;
`ifdef SEQ1101_TX_PARITY_EN
                        par_q     <= ^bus.in_data;
                        par_done  <= 1'b0;
`endif
                        state     <= SYNC;
                        idx       <= '0;
                        tx_bit    <= SYNC_WORD[3];
                        tx_active <= 1'b1;
                        tx_sync   <= 1'b1;
                    end
                end
                SYNC: begin
                    if (!go_resume) begin
                        idx    <= idx + IDX_W'(1);
                        tx_bit <= SYNC_WORD[2'd2 - idx[1:0]];
                    end
                end
                GAP: begin
                    hist <= '0;
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                end
            endcase

            if (go_stuff) begin
                state    <= STUFF;
                idx      <= res_n;
                tx_bit   <= 1'b0;
                tx_stuff <= 1'b1;
            end else if (go_resume) begin
                state     <= res_state;
                tx_bit    <= res_bit;
                tx_active <= res_active;
                tx_sync   <= 1'b0;
                tx_stuff  <= 1'b0;
                if (res_state == DATA) begin
                    data_q <= data_q << 1;
                    idx    <= res_n;
                end
                if (res_state == GAP) begin
                    frame_done <= 1'b1;
                    gap_cnt    <= '0;
                end
`ifdef SEQ1101_TX_PARITY_EN
                if (res_state == PAR) begin
                    par_done <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: doc/seq1101_tx.md
Name: seq1101_tx

Overview:
- Framed serial transmitter. Emits the 4-bit sync word 1101, then a DATA_W-bit payload MSB first, one bit per clock.
- Inserts stuff bits so that 1101 never appears inside the frame body. A downstream 1101 sequence detector therefore fires only on the real sync word.
- Sits between a parallel valid/ready producer and a single-bit serial line.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- GAP_CYCLES, 2, number of idle 0 bits driven after each frame before the next is accepted (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_data  input  DATA_W  payload word
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word; = (state==IDLE) && !rst
- tx_bit  output  1  serial line, registered
- tx_active  output  1  high for every frame bit: sync, data, stuff, parity
- tx_sync  output  1  high while a sync-word bit is on tx_bit
- tx_stuff  output  1  high while a stuffed 0 is on tx_bit
- frame_done  output  1  one-cycle pulse in the first GAP cycle

Behaviour:
- Single clock; all state changes on rising clk edge. Reset is synchronous and active-high.
- Reset:
  - state=IDLE, tx_bit=0, tx_active=0, tx_sync=0, tx_stuff=0, frame_done=0, hist=000.
  - Latched payload is discarded. Reset mid-frame aborts the frame; the line returns to 0 the next cycle.
- States: IDLE, SYNC, DATA, STUFF, PAR (macro only), GAP.
- IDLE:
  - tx_bit=0, hist=000, in_ready=1.
  - Handshake in_valid && in_ready latches in_data; next cycle goes to SYNC with idx=0.
  - in_data does not need to be held after acceptance.
- SYNC:
  - Over 4 cycles, tx_bit = 1,1,0,1 with tx_sync=1.
  - After idx 3 go to DATA. No stuffing inside SYNC.
- DATA:
  - tx_bit = data[DATA_W-1-k] for k = 0..DATA_W-1, one per cycle.
  - After the last bit go to PAR if the macro is defined, else GAP (via STUFF if required).
- hist:
  - 3-bit shift register of the most recent emitted frame bits, including sync, stuff and parity bits.
  - Updated every cycle tx_active=1.
- Stuff rule:
  - After a DATA or PAR bit is emitted, if hist (oldest..newest) == 110, the next cycle is STUFF.
  - STUFF: tx_bit=0, tx_stuff=1. Then resume at the pending state: next data bit, PAR, or GAP.
  - Stuffing applies after the final payload/parity bit as well, so the decoder rule is unconditional: drop the 0 after every 110 in the body.
  - STUFF never chains, because hist ends in 0 after a stuff bit.
- Frame length = 4 + DATA_W + number of stuff bits (+1 with parity). Latency from accept to first sync bit on tx_bit is 1 cycle.
- GAP:
  - tx_bit=0, tx_active=0 for GAP_CYCLES cycles; frame_done=1 in the first GAP cycle only.
  - Then return to IDLE.
  - in_ready=0 in every state except IDLE. A word held valid during a frame is accepted on the first IDLE cycle.
- Back-to-back frames are separated by GAP_CYCLES zeros plus at least 1 IDLE cycle.

Optional Feature:
- Macro SEQ1101_TX_PARITY_EN.
- Defined:
  - After the last data bit (and any stuff bit), one PAR cycle emits even parity = XOR of the payload. tx_active=1 in that cycle.
  - The parity bit enters hist and is subject to the stuff rule.
- Not defined: no PAR state; frame ends after the payload and any trailing stuff bit.

Test Plan:
- Reset, then in_data=8'hFF valid -> tx_bit 1101_11111111, no tx_stuff, then 00 gap. frame_done 1 cycle. tx_active high 12 cycles.
- in_data=8'hD0 -> 1101_110[0]10000, stuff at body position 4, 13 active cycles. The 4-bit window never matches 1101 after the sync word.
- in_data=8'hB0 -> 1101_10[0]110[0]0000, two stuffs (header/body boundary case), 14 active cycles.
- in_valid held high with 8'h80 then 8'h01 -> first frame 1101_10[0]000000. in_ready low until the IDLE cycle after 2 gap cycles. Second frame 1101_00000001 follows.
- rst=1 for 1 cycle at the 6th frame bit -> next cycle tx_bit=0, tx_active=0, state IDLE, in_ready=1 the cycle after rst drops. No frame_done.
- SEQ1101_TX_PARITY_EN, in_data=8'h06 -> 1101_00000110[0] then parity 0. Stuff precedes PAR; 14 active cycles.
